uart_tx_fifo_core: RTL and testbench
====================================

Name: uart_tx_fifo_core

Overview:
Parametrised UART transmitter for the AXI-lite UART IP.
- Has a built-in TX FIFO, so the bus side can queue several characters.
- Data length is selectable at runtime: 5/6/7/8 bits.
- Parity modes: none, even, odd, mark, space.
- Stop bits: 1 or 2.
- Sits between the register-file write path and the tx pad.

Parameters:
DIV_SIZE, 16, width of baud divisor
FIFO_DEPTH, 8, TX FIFO entries; power of two, minimum 2
DATA_MAX, 8, maximum character width; fixed at 8

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
en_i  in  1  transmitter enable; gates the start of new frames only
data_bits_i  in  2  character length: 00=5, 01=6, 10=7, 11=8
parity_en_i  in  1  1 = append parity bit
parity_mode_i  in  2  00=even, 01=odd, 10=mark (1), 11=space (0)
stop_bits_i  in  1  0 = one stop bit, 1 = two stop bits
baud_div_i  in  DIV_SIZE  bit period = baud_div_i+1 clk cycles
flush_i  in  1  synchronous FIFO clear
tx_data_i  in  8  character to queue
tx_valid_i  in  1  push request
tx_ready_o  out  1  FIFO not full
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
break_i  in  1  line-break request (see Optional Feature)
tx_o  out  1  serial output, idle high
busy_o  out  1  frame or break in progress
done_o  out  1  one-cycle pulse at end of each frame

Behaviour:
- Reset values: tx_o=1, busy_o=0, done_o=0, fifo_level_o=0, tx_ready_o=1, FSM in IDLE.
- Reset mid-frame aborts the frame; tx_o returns high asynchronously.
- FIFO push occurs when tx_valid_i & tx_ready_o; tx_ready_o = !full, registered-state derived.
- Push and pop in the same cycle: level unchanged.
- Push while full: ignored, data dropped, level unchanged.
- flush_i: level <- 0 on the next edge; flush wins over a simultaneous push. It does not abort the frame in flight.
- Config latch: data_bits_i, parity_en_i, parity_mode_i, stop_bits_i and baud_div_i are captured at frame start. Changes mid-frame take effect on the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE:
  - if en_i & !empty: pop head, latch config, tx_o<=0, busy_o<=1, go to START.
  - else tx_o=1 and busy_o=0.
- Bit timing: each state holds tx_o for exactly baud_div_i+1 cycles, using counter cnt from 0 to div. First start-bit cycle is the cycle after the pop edge.
- START -> DATA: shift LSB first, N = 5..8 bits.
- After the last data bit:
  - parity_en_i=1: go to PARITY. Even = XOR of the N data bits; odd = its inverse; mark = 1; space = 0. Unused upper bits are masked.
  - parity_en_i=0: go to STOP.
- STOP: tx_o=1 for 1 or 2 bit periods. In the final cycle of the last stop bit:
  - done_o=1 for one cycle;
  - if en_i & !empty, pop and enter START directly (back-to-back frames, no idle gap, busy_o stays 1);
  - else go to IDLE.
- Frame length = (1 + N + P + S) × (baud_div_i+1) cycles.
- en_i deasserted mid-frame: the current frame completes; no further pops.
- baud_div_i=0: one cycle per bit; must work.

Optional Feature:
Macro UART_TX_BREAK_EN.
- Defined:
  - break_i is sampled only at frame boundaries (IDLE, or the final STOP cycle) and takes priority over popping.
  - BREAK state drives tx_o=0 while break_i=1, for a minimum of one full frame time at the latched config.
  - On release: tx_o=1 for one bit period, then IDLE. busy_o=1 throughout; no done_o pulse.
- Undefined: break_i is ignored, the BREAK state is not synthesised, and tx_o is never held low outside a frame.

Decomposition:
- Package uart_pkg:
  - FSM state enum;
  - parity mode encodings (PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE);
  - data-length encoding;
  - function mapping data_bits_i to the bit count.
- Sub-module uart_sync_fifo: a synchronous FIFO with width 8, depth FIFO_DEPTH, and push/pop/flush/full/empty/level.

Test Plan:
- baud_div=3, 8N1, push 0xA5 -> tx_o = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; done_o at cycle 40; busy_o low afterwards.
- baud_div=1, 7E2, push 0x41 -> start, data 1000001, parity 0, two stop bits; frame = 22 cycles.
- FIFO_DEPTH=4, en_i=0, push 5 bytes -> tx_ready_o low after the 4th push; 5th push dropped; fifo_level_o=4. Then set en_i=1 -> 4 back-to-back frames with no idle gap.
- Mid-frame change of baud_div 3->7 and parity odd->none -> current frame unchanged; next frame uses the new config.
- Assert rstn_i low during DATA -> tx_o=1 and busy_o=0 immediately; fifo_level_o=0.
- With UART_TX_BREAK_EN: hold break_i for 100 cycles at baud_div=3, 8N1 -> tx_o low for max(100, 40) cycles, then high for 4 cycles, then IDLE; no done_o pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART transmitter types: FSM states, parity/length encodings, latched frame config.
// Pure definitions and combinational helpers; no latency, no flow control.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_e;

  localparam logic [1:0] PAR_EVEN  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  localparam logic [1:0] LEN_5 = 2'b00;
  localparam logic [1:0] LEN_6 = 2'b01;
  localparam logic [1:0] LEN_7 = 2'b10;
  localparam logic [1:0] LEN_8 = 2'b11;

  typedef struct packed {
    logic [1:0] len;
    logic       par_en;
    logic       stop2;
  } frame_cfg_t;

  function automatic logic [3:0] data_bits_count(input logic [1:0] len);
    case (len)
      LEN_5:   data_bits_count = 4'd5;
      LEN_6:   data_bits_count = 4'd6;
      LEN_7:   data_bits_count = 4'd7;
      LEN_8:   data_bits_count = 4'd8;
      default: data_bits_count = 4'd8;
    endcase
  endfunction

  // Bits above the character length never contribute to parity.
  function automatic logic calc_parity(input logic [7:0] dat, input logic [1:0] len,
                                       input logic [1:0] mode);
    logic [7:0] mask;
    logic       even;
    mask = 8'hFF >> (2'd3 - len);
    even = ^(dat & mask);
    case (mode)
      PAR_EVEN:  calc_parity = even;
      PAR_ODD:   calc_parity = ~even;
      PAR_MARK:  calc_parity = 1'b1;
      PAR_SPACE: calc_parity = 1'b0;
      default:   calc_parity = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with flush; data visible at the head the cycle after a push.
// Pushes while full and pops while empty are ignored; flush clears occupancy and beats a push.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wr_dat,
  output logic [WIDTH-1:0]         rd_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = level[AW];
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_dat  = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/uart_tx_fifo_core.sv
// FIFO-fed UART transmitter: first start bit one cycle after the pop; tx_ready_o = FIFO not full.
// UART_TX_BREAK_EN adds a line-break state taking priority over pops at frame boundaries.
module uart_tx_fifo_core
  import uart_pkg::*;
#(
  parameter int DIV_SIZE   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_MAX   = 8
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          en_i,
  input  logic [1:0]                    data_bits_i,
  input  logic                          parity_en_i,
  input  logic [1:0]                    parity_mode_i,
  input  logic                          stop_bits_i,
  input  logic [DIV_SIZE-1:0]           baud_div_i,
  input  logic                          flush_i,
  input  logic [DATA_MAX-1:0]           tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  input  logic                          break_i,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic                          done_o
);

  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic [DATA_MAX-1:0] fifo_rd_dat;

  uart_sync_fifo #(
    .WIDTH (DATA_MAX),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .push   (tx_valid_i),
    .pop    (fifo_pop),
    .flush  (flush_i),
    .wr_dat (tx_data_i),
    .rd_dat (fifo_rd_dat),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level_o)
  );

  assign tx_ready_o = ~fifo_full;

  uart_state_e         state_q, state_d;
  logic [DIV_SIZE-1:0] cnt_q, cnt_d;
  logic [DIV_SIZE-1:0] div_q, div_d;
  frame_cfg_t          cfg_q, cfg_d;
  logic [DATA_MAX-1:0] shreg_q, shreg_d;
  logic [2:0]          bit_q, bit_d;
  logic                stop_q, stop_d;
  logic                par_q, par_d;
  logic                launch_frm;
  logic                bit_end;
  logic                start_ok;
  logic [3:0]          nbits;

  assign bit_end  = (cnt_q == div_q);
  assign start_ok = en_i & ~fifo_empty;
  assign nbits    = data_bits_count(cfg_q.len);

`ifdef UART_TX_BREAK_EN
  logic       brk_rel_q, brk_rel_d;
  logic [3:0] brk_bits_q, brk_bits_d;
  logic [3:0] frame_bits;
  logic       brk_min_met;
  logic       launch_brk;

  assign frame_bits  = 4'd1 + nbits + {3'b000, cfg_q.par_en} + (cfg_q.stop2 ? 4'd2 : 4'd1);
  // Minimum low time is reached on the cycle that completes the last bit period of a frame.
  assign brk_min_met = (brk_bits_q == frame_bits) ||
                       (bit_end && (brk_bits_q == frame_bits - 4'd1));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      brk_rel_q  <= 1'b0;
      brk_bits_q <= '0;
    end else begin
      brk_rel_q  <= brk_rel_d;
      brk_bits_q <= brk_bits_d;
    end
  end
`else
  logic unused_break;
  assign unused_break = break_i;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      cfg_q   <= '0;
      shreg_q <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      cfg_q   <= cfg_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      par_q   <= par_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = bit_end ? '0 : cnt_q + 1'b1;
    div_d      = div_q;
    cfg_d      = cfg_q;
    shreg_d    = shreg_q;
    bit_d      = bit_q;
    stop_d     = stop_q;
    par_d      = par_q;
    fifo_pop   = 1'b0;
    launch_frm = 1'b0;
    tx_o       = 1'b1;
    busy_o     = 1'b1;
    done_o     = 1'b0;
`ifdef UART_TX_BREAK_EN
    brk_rel_d  = brk_rel_q;
    brk_bits_d = brk_bits_q;
    launch_brk = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        cnt_d  = '0;
`ifdef UART_TX_BREAK_EN
        if (break_i)       launch_brk = 1'b1;
        else if (start_ok) launch_frm = 1'b1;
`else
        if (start_ok) launch_frm = 1'b1;
`endif
      end
      START: begin
        tx_o = 1'b0;
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        tx_o = shreg_q[0];
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          bit_d   = bit_q + 3'd1;
          stop_d  = 1'b0;
          if (bit_q == 3'(nbits - 4'd1)) state_d = cfg_q.par_en ? PARITY : STOP;
        end
      end
      PARITY: begin
        tx_o = par_q;
        if (bit_end) begin
          state_d = STOP;
          stop_d  = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (cfg_q.stop2 && !stop_q) begin
            stop_d = 1'b1;
          end else begin
            done_o  = 1'b1;
            state_d = IDLE;
`ifdef UART_TX_BREAK_EN
            if (break_i)       launch_brk = 1'b1;
            else if (start_ok) launch_frm = 1'b1;
`else
            if (start_ok) launch_frm = 1'b1;
`endif
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        tx_o = brk_rel_q;
        if (!brk_rel_q) begin
          if (bit_end && (brk_bits_q != frame_bits)) brk_bits_d = brk_bits_q + 4'd1;
          if (!break_i && brk_min_met) begin
            brk_rel_d = 1'b1;
            cnt_d     = '0;
          end
        end else if (bit_end) begin
          state_d = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Config and character are captured together so mid-frame input changes only affect the next frame.
    if (launch_frm) begin
      fifo_pop     = 1'b1;
      state_d      = START;
      cnt_d        = '0;
      div_d        = baud_div_i;
      cfg_d.len    = data_bits_i;
      cfg_d.par_en = parity_en_i;
      cfg_d.stop2  = stop_bits_i;
      shreg_d      = fifo_rd_dat;
      par_d        = calc_parity(fifo_rd_dat, data_bits_i, parity_mode_i);
      bit_d        = '0;
      stop_d       = 1'b0;
    end
`ifdef UART_TX_BREAK_EN
    if (launch_brk) begin
      state_d      = BREAK;
      cnt_d        = '0;
      div_d        = baud_div_i;
      cfg_d.len    = data_bits_i;
      cfg_d.par_en = parity_en_i;
      cfg_d.stop2  = stop_bits_i;
      brk_bits_d   = '0;
      brk_rel_d    = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_uart_tx_fifo_core.sv
// Directed bench for uart_tx_fifo_core: frame shapes, FIFO limits, config latching, reset, break.
module tb_uart_tx_fifo_core;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic [1:0]  data_bits;
  logic        parity_en;
  logic [1:0]  parity_mode;
  logic        stop_bits;
  logic [15:0] baud_div;
  logic        flush;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [2:0]  fifo_level;
  logic        brk;
  logic        tx;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_core #(
    .DIV_SIZE   (16),
    .FIFO_DEPTH (4),
    .DATA_MAX   (8)
  ) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .en_i          (en),
    .data_bits_i   (data_bits),
    .parity_en_i   (parity_en),
    .parity_mode_i (parity_mode),
    .stop_bits_i   (stop_bits),
    .baud_div_i    (baud_div),
    .flush_i       (flush),
    .tx_data_i     (tx_data),
    .tx_valid_i    (tx_valid),
    .tx_ready_o    (tx_ready),
    .fifo_level_o  (fifo_level),
    .break_i       (brk),
    .tx_o          (tx),
    .busy_o        (busy),
    .done_o        (done)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic set_cfg(input logic [1:0] len, input logic pen, input logic [1:0] pmode,
                         input logic stop2, input logic [15:0] div);
    data_bits   = len;
    parity_en   = pen;
    parity_mode = pmode;
    stop_bits   = stop2;
    baud_div    = div;
  endtask

  // bits[k] is the k-th transmitted bit; every cycle of the frame is compared.
  task automatic run_frame(input string tag, input logic [11:0] bits, input int nb,
                           input int div, output int waited);
    int errs_tx;
    int errs_done;
    int errs_busy;
    int len;
    errs_tx   = 0;
    errs_done = 0;
    errs_busy = 0;
    waited    = 0;
    while (tx !== 1'b0 && waited < 1000) begin
      tick();
      waited++;
    end
    check_val({tag, "_start"}, tx, 0);
    len = nb * (div + 1);
    for (int i = 0; i < len; i++) begin
      if (tx !== bits[i / (div + 1)]) errs_tx++;
      if (done !== (i == len - 1)) errs_done++;
      if (busy !== 1'b1) errs_busy++;
      tick();
    end
    check_val({tag, "_tx_errs"}, errs_tx, 0);
    check_val({tag, "_done_errs"}, errs_done, 0);
    check_val({tag, "_busy_errs"}, errs_busy, 0);
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic break_run(input int hold, output int lows, output int rels, output int dones);
    int guard;
    lows  = 0;
    rels  = 0;
    dones = 0;
    brk   = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (tx === 1'b0) lows++;
      if (done === 1'b1) dones++;
    end
    brk   = 1'b0;
    guard = 0;
    while (guard < 1000) begin
      tick();
      guard++;
      if (busy !== 1'b1) break;
      if (tx === 1'b0) lows++;
      else rels++;
      if (done === 1'b1) dones++;
    end
    check_val("break_ends_idle", busy, 0);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time limit expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0, w1, w2, w3;
    int cnt_a, cnt_b;
    logic [7:0] bytes [5];
    logic [11:0] exp_bits [4];
    bytes    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    exp_bits = '{12'h062, 12'h044, 12'h066, 12'h048};

    rstn     = 1'b0;
    en       = 1'b0;
    flush    = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    brk      = 1'b0;
    set_cfg(2'b11, 1'b0, 2'b00, 1'b0, 16'd3);
    #23;
    check_val("rst_tx", tx, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_level", fifo_level, 0);
    check_val("rst_ready", tx_ready, 1);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // 8N1, div 3, 0xA5
    en = 1'b1;
    push(8'hA5);
    run_frame("a5_8n1", 12'h34A, 10, 3, w0);
    check_val("a5_latency", w0, 1);
    check_val("a5_idle_busy", busy, 0);
    check_val("a5_idle_tx", tx, 1);

    // 7E2, div 1, 0x41
    set_cfg(2'b10, 1'b1, 2'b00, 1'b1, 16'd1);
    push(8'h41);
    run_frame("41_7e2", 12'h682, 11, 1, w0);
    check_val("41_latency", w0, 1);
    check_val("41_idle_busy", busy, 0);

    // FIFO fill with transmitter disabled, then back-to-back 5N1 frames at div 0
    en = 1'b0;
    set_cfg(2'b00, 1'b0, 2'b00, 1'b0, 16'd0);
    for (int i = 0; i < 5; i++) begin
      push(bytes[i]);
      check_val($sformatf("fill_ready%0d", i), tx_ready, (i < 3) ? 1 : 0);
      check_val($sformatf("fill_level%0d", i), fifo_level, (i < 4) ? i + 1 : 4);
    end
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_frame($sformatf("b2b%0d", k), exp_bits[k], 7, 0, w0);
      check_val($sformatf("b2b%0d_gap", k), w0, (k == 0) ? 1 : 0);
    end
    check_val("b2b_level_end", fifo_level, 0);
    tick();
    tick();
    check_val("b2b_dropped_busy", busy, 0);

    // Config change mid-frame: div 3 -> 7, odd parity -> none
    en = 1'b0;
    push(8'h00);
    push(8'h0F);
    set_cfg(2'b11, 1'b1, 2'b01, 1'b0, 16'd3);
    en = 1'b1;
    fork
      begin
        run_frame("cfg_old", 12'h600, 11, 3, w1);
        run_frame("cfg_new", 12'h21E, 10, 7, w2);
      end
      begin
        repeat (12) tick();
        baud_div  = 16'd7;
        parity_en = 1'b0;
      end
    join
    check_val("cfg_old_latency", w1, 1);
    check_val("cfg_new_gap", w2, 0);
    check_val("cfg_idle_busy", busy, 0);

    // Flush, including flush racing a push
    en = 1'b0;
    push(8'h01);
    push(8'h02);
    check_val("flush_pre_level", fifo_level, 2);
    flush    = 1'b1;
    tx_valid = 1'b1;
    tick();
    flush    = 1'b0;
    tx_valid = 1'b0;
    check_val("flush_level", fifo_level, 0);
    en = 1'b1;
    tick();
    tick();
    check_val("flush_no_frame", busy, 0);

    // Asynchronous reset inside DATA
    en = 1'b0;
    set_cfg(2'b11, 1'b0, 2'b00, 1'b0, 16'd3);
    push(8'h00);
    push(8'h00);
    en = 1'b1;
    w3 = 0;
    while (tx !== 1'b0 && w3 < 100) begin
      tick();
      w3++;
    end
    repeat (6) tick();
    check_val("mid_data_tx", tx, 0);
    check_val("mid_data_busy", busy, 1);
    rstn = 1'b0;
    #1;
    check_val("arst_tx", tx, 1);
    check_val("arst_busy", busy, 0);
    check_val("arst_level", fifo_level, 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    tick();
    check_val("post_rst_busy", busy, 0);

`ifdef UART_TX_BREAK_EN
    en = 1'b0;
    set_cfg(2'b11, 1'b0, 2'b00, 1'b0, 16'd3);
    break_run(100, cnt_a, cnt_b, w0);
    check_val("brk100_low", cnt_a, 100);
    check_val("brk100_rel", cnt_b, 4);
    check_val("brk100_done", w0, 0);
    break_run(1, cnt_a, cnt_b, w0);
    check_val("brk1_low", cnt_a, 40);
    check_val("brk1_rel", cnt_b, 4);
    check_val("brk1_done", w0, 0);
`else
    // Without break support the line stays idle and frames are unaffected
    en    = 1'b1;
    brk   = 1'b1;
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx !== 1'b1) cnt_a++;
      if (busy !== 1'b0) cnt_b++;
    end
    check_val("nobrk_tx_low", cnt_a, 0);
    check_val("nobrk_busy", cnt_b, 0);
    set_cfg(2'b11, 1'b0, 2'b00, 1'b0, 16'd3);
    push(8'hA5);
    run_frame("nobrk_a5", 12'h34A, 10, 3, w0);
    brk = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
